// File: rtl/ide_pio_pkg.sv
// Shared types and default ATA PIO timing for the IDE PIO sequencer.
// Timing values are counted in clk cycles at 12.5 MHz.
package ide_pio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      SETUP,
      STROBE,
      RECOV
   } state_t;

   localparam int T_SETUP_DEF = 1;
   localparam int T_PULSE_DEF = 4;
   localparam int T_RECOV_DEF = 3;

   localparam logic [1:0] CS_IDLE = 2'b11;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ide_pio_sequencer_if.sv
// Request and data-stream handshake between the disk controller (master)
// and the PIO sequencer (slave).
interface ide_pio_sequencer_if;

   logic        req;
   logic        write;
   logic [4:0]  addr;
   logic [7:0]  len;
   logic        ack;
   logic        busy;
   logic [15:0] wdata;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        done;

   modport master (
      output req, write, addr, len, wdata, wdata_valid,
      input  ack, busy, wdata_ready, rdata, rdata_valid, done
   );

   modport slave (
      input  req, write, addr, len, wdata, wdata_valid,
      output ack, busy, wdata_ready, rdata, rdata_valid, done
   );

endinterface

// File: rtl/ide_pio_sequencer.sv
// ATA PIO cycle sequencer: per word, address setup, one dior/diow pulse and
// recovery, all timed by a single phase down-counter.
module ide_pio_sequencer
   import ide_pio_pkg::*;
#(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_PULSE = T_PULSE_DEF,
   parameter int T_RECOV = T_RECOV_DEF
) (
   input  logic                clk,
   input  logic                reset,
   ide_pio_sequencer_if.slave  host,
   input  logic [15:0]         ide_data_in,
   output logic [15:0]         ide_data_out,
   output logic                ide_dior,
   output logic                ide_diow,
   output logic [1:0]          ide_cs,
   output logic [2:0]          ide_da
);

   localparam int TMAX = max3(T_SETUP, T_PULSE, T_RECOV);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   if (T_SETUP < 1 || T_PULSE < 1 || T_RECOV < 1) begin : g_bad_timing
      $error("ide_pio_sequencer: T_SETUP, T_PULSE and T_RECOV must all be >= 1");
   end

   state_t          state, state_d;
   logic [TW-1:0]   tmr, tmr_d;
   logic [8:0]      words, words_d;
   logic            write_q, write_d;
   logic [4:0]      addr_q, addr_d;
   logic [15:0]     dout_q, dout_d;
   logic [15:0]     rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            done_q, done_d;
   logic            accept;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d  = state;
      tmr_d    = tmr;
      words_d  = words;
      write_d  = write_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
      accept   = 1'b0;

      unique case (state)
         IDLE: begin
            // The done cycle still counts as busy, so re-accept waits one cycle.
            if (host.req && !done_q && !reset) begin
               accept  = 1'b1;
               write_d = host.write;
               addr_d  = host.addr;
               words_d = (host.len == 8'd0) ? 9'd256 : {1'b0, host.len};
               if (host.write) begin
                  state_d = WAIT_DATA;
               end else begin
                  state_d = SETUP;
                  tmr_d   = TW'(T_SETUP - 1);
               end
            end
         end
         WAIT_DATA: begin
            if (host.wdata_valid) begin
               dout_d  = host.wdata;
               state_d = SETUP;
               tmr_d   = TW'(T_SETUP - 1);
            end
         end
         SETUP: begin
            if (tmr == '0) begin
               state_d = STROBE;
               tmr_d   = TW'(T_PULSE - 1);
            end else begin
               tmr_d = tmr - 1'b1;
            end
         end
         STROBE: begin
            if (tmr == '0) begin
               state_d = RECOV;
               tmr_d   = TW'(T_RECOV - 1);
               if (!write_q) begin
                  rdata_d  = ide_data_in;
                  rvalid_d = 1'b1;
               end
            end else begin
               tmr_d = tmr - 1'b1;
            end
         end
         RECOV: begin
            if (tmr == '0) begin
               words_d = words - 9'd1;
               if (words == 9'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (write_q) begin
                  state_d = WAIT_DATA;
               end else begin
                  state_d = SETUP;
                  tmr_d   = TW'(T_SETUP - 1);
               end
            end else begin
               tmr_d = tmr - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pins are registered from the next state: glitch-free strobes that track the state exactly.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         tmr      <= '0;
         words    <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         ide_dior <= 1'b1;
         ide_diow <= 1'b1;
         ide_cs   <= CS_IDLE;
         ide_da   <= '0;
      end else begin
         state    <= state_d;
         tmr      <= tmr_d;
         words    <= words_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
         ide_dior <= !(state_d == STROBE && !write_d);
         ide_diow <= !(state_d == STROBE && write_d);
         ide_cs   <= (state_d == IDLE) ? CS_IDLE : addr_d[4:3];
         ide_da   <= (state_d == IDLE) ? 3'd0 : addr_d[2:0];
      end
   end

   assign ide_data_out     = dout_q;
   assign host.ack         = accept;
   assign host.busy        = (state != IDLE) || done_q;
   assign host.wdata_ready = (state == WAIT_DATA);
   assign host.rdata       = rdata_q;
   assign host.rdata_valid = rvalid_q;
   assign host.done        = done_q;

endmodule
